// File: rtl/divider_8b_seq_if.sv
// Operand/result handshake bundle for the 8/4 sequential divider.
// master = requester (drives operands, accepts results); slave = divider.
interface divider_8b_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x;
  logic [3:0] y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;
  logic [3:0] r;
  logic       dz;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, q, r, dz
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, q, r, dz
  );
endinterface

// File: rtl/divider_8b_seq.sv
// Radix-2 restoring unsigned divider, 8b dividend / 4b divisor, one quotient
// bit per clock, valid/ready on both operand and result sides.

// One restoring step: shift the next dividend bit into the partial remainder,
// then trial-subtract the divisor at 5-bit width.
module div_step (
  input  logic [4:0] r_in,
  input  logic       d_msb,
  input  logic [3:0] div,
  output logic [4:0] r_out,
  output logic       q_bit
);
  logic [4:0] t;
  logic [4:0] y_ext;
  logic       unused_r_msb;

  // r_in < div <= 15 holds between steps, so r_in[4] is always zero.
  assign unused_r_msb = r_in[4];

  always_comb begin
    t     = {r_in[3:0], d_msb};
    y_ext = {1'b0, div};
    q_bit = (t >= y_ext);
    r_out = q_bit ? (t - y_ext) : t;
  end
endmodule

module divider_8b_seq (
  input logic           clk,
  input logic           rst_n,
  divider_8b_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;

  logic [7:0] d_q;
  logic [7:0] qs_q;
  logic [3:0] y_q;
  logic [4:0] r_q;
  logic [2:0] cnt_q;

  logic [7:0] q_o;
  logic [3:0] r_o;
  logic       dz_o;

  logic [4:0] r_nx;
  logic       q_bit;
  logic [7:0] qs_nx;
  logic       accept;
  logic       last_iter;
  logic       div_zero;

  div_step u_step (
    .r_in  (r_q),
    .d_msb (d_q[7]),
    .div   (y_q),
    .r_out (r_nx),
    .q_bit (q_bit)
  );

  assign qs_nx     = {qs_q[6:0], q_bit};
  assign accept    = bus.in_valid && (state_q == IDLE);
  assign last_iter = (state_q == RUN) && (cnt_q == 3'd7);
  assign div_zero  = (bus.y == 4'd0);

  // Handshake outputs come only from the registered state.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.q         = q_o;
  assign bus.r         = r_o;
  assign bus.dz        = dz_o;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = div_zero ? DONE : RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working registers and result registers; results change only on DONE entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q   <= '0;
      qs_q  <= '0;
      y_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      q_o   <= '0;
      r_o   <= '0;
      dz_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (div_zero) begin
              q_o  <= 8'hFF;
              r_o  <= bus.x[3:0];
              dz_o <= 1'b1;
            end else begin
              d_q   <= bus.x;
              y_q   <= bus.y;
              r_q   <= '0;
              qs_q  <= '0;
              cnt_q <= '0;
            end
          end
        end
        RUN: begin
          d_q   <= {d_q[6:0], 1'b0};
          r_q   <= r_nx;
          qs_q  <= qs_nx;
          cnt_q <= cnt_q + 3'd1;
          if (last_iter) begin
            q_o  <= qs_nx;
            r_o  <= r_nx[3:0];
            dz_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_8b_seq.sv
// Directed-vector bench for divider_8b_seq: latency, backpressure, reset
// abort, divide-by-zero and a full 256x16 operand sweep.
module tb_divider_8b_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  divider_8b_seq_if bus();

  divider_8b_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold operands until the divider takes them; returns 1 time unit after the accept edge.
  task automatic do_accept(input logic [7:0] xv, input logic [3:0] yv);
    int guard;
    guard = 0;
    bus.x = xv;
    bus.y = yv;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, guard);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.x = 8'h12;
    bus.y = 4'd0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_hs: in_ready/out_valid=%b, required 10", {bus.in_ready, bus.out_valid});
    end
    n_vec++;
    if ({bus.q, bus.r, bus.dz} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_out: q=%0d r=%0d dz=%0b, required 0 0 0", bus.q, bus.r, bus.dz);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL post_reset_hs: in_ready/out_valid=%b, required 10", {bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_basic();
    int cyc;
    do_accept(8'd200, 4'd7);
    wait_out(cyc);
    n_vec++;
    if (cyc !== 8) begin
      n_err++;
      $display("FAIL basic_latency: %0d cycles, required 8", cyc);
    end
    n_vec++;
    if ({bus.q, bus.r, bus.dz} !== {8'd28, 4'd4, 1'b0}) begin
      n_err++;
      $display("FAIL basic_result: q=%0d r=%0d dz=%0b, required 28 4 0", bus.q, bus.r, bus.dz);
    end
    tick();
    n_vec++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL basic_width: in_ready/out_valid=%b, required 10", {bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_vectors();
    logic [7:0] tx [3];
    logic [3:0] ty [3];
    logic [7:0] tq [3];
    logic [3:0] tr [3];
    int cyc;
    tx = '{8'd255, 8'd5, 8'd255};
    ty = '{4'd1,   4'd9, 4'd15};
    tq = '{8'd255, 8'd0, 8'd17};
    tr = '{4'd0,   4'd5, 4'd0};
    for (int i = 0; i < 3; i++) begin
      do_accept(tx[i], ty[i]);
      wait_out(cyc);
      n_vec++;
      if ({bus.out_valid, bus.q, bus.r, bus.dz} !== {1'b1, tq[i], tr[i], 1'b0}) begin
        n_err++;
        $display("FAIL vec%0d: valid=%0b q=%0d r=%0d dz=%0b, required 1 %0d %0d 0",
                 i, bus.out_valid, bus.q, bus.r, bus.dz, tq[i], tr[i]);
      end
      tick();
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    do_accept(8'd123, 4'd0);
    // Zero divisor skips RUN: DONE is entered on the accept edge itself.
    wait_out(cyc);
    n_vec++;
    if (cyc !== 0) begin
      n_err++;
      $display("FAIL dz_latency: %0d extra cycles, required 0", cyc);
    end
    n_vec++;
    if ({bus.q, bus.r, bus.dz} !== {8'hFF, 4'hB, 1'b1}) begin
      n_err++;
      $display("FAIL dz_result: q=%h r=%h dz=%0b, required ff b 1", bus.q, bus.r, bus.dz);
    end
    tick();
    n_vec++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL dz_release: in_ready/out_valid=%b, required 10", {bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bus.out_ready = 1'b0;
    do_accept(8'd100, 4'd3);
    tick();
    bus.x = 8'd9;
    bus.y = 4'd2;
    bus.in_valid = 1'b1;
    n_vec++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_run_ready: in_ready=%0b, required 0", bus.in_ready);
    end
    wait_out(cyc);
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if ({bus.out_valid, bus.in_ready, bus.q, bus.r, bus.dz} !== {1'b1, 1'b0, 8'd33, 4'd1, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold%0d: valid=%0b ready=%0b q=%0d r=%0d dz=%0b, required 1 0 33 1 0",
                 i, bus.out_valid, bus.in_ready, bus.q, bus.r, bus.dz);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_vec++;
    if ({bus.in_ready, bus.out_valid, bus.q, bus.r} !== {1'b1, 1'b0, 8'd33, 4'd1}) begin
      n_err++;
      $display("FAIL bp_release: ready=%0b valid=%0b q=%0d r=%0d, required 1 0 33 1",
               bus.in_ready, bus.out_valid, bus.q, bus.r);
    end
    do_accept(8'd9, 4'd2);
    wait_out(cyc);
    n_vec++;
    if ({cyc[3:0], bus.q, bus.r, bus.dz} !== {4'd8, 8'd4, 4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL bp_next: cyc=%0d q=%0d r=%0d dz=%0b, required 8 4 1 0", cyc, bus.q, bus.r, bus.dz);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    int cyc;
    int stray;
    do_accept(8'd77, 4'd5);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++;
    if ({bus.out_valid, bus.in_ready, bus.q, bus.r, bus.dz} !== {1'b0, 1'b1, 13'd0}) begin
      n_err++;
      $display("FAIL abort_state: valid=%0b ready=%0b q=%0d r=%0d dz=%0b, required 0 1 0 0 0",
               bus.out_valid, bus.in_ready, bus.q, bus.r, bus.dz);
    end
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid) stray++;
    end
    n_vec++;
    if (stray !== 0) begin
      n_err++;
      $display("FAIL abort_stray: %0d out_valid cycles, required 0", stray);
    end
    do_accept(8'd77, 4'd5);
    wait_out(cyc);
    n_vec++;
    if ({cyc[3:0], bus.q, bus.r, bus.dz} !== {4'd8, 8'd15, 4'd2, 1'b0}) begin
      n_err++;
      $display("FAIL abort_retry: cyc=%0d q=%0d r=%0d dz=%0b, required 8 15 2 0", cyc, bus.q, bus.r, bus.dz);
    end
    tick();
  endtask

  task automatic test_sweep();
    int cyc;
    logic [7:0] eq;
    logic [3:0] er;
    logic       edz;
    logic       ok;
    for (int xi = 0; xi < 256; xi++) begin
      for (int yi = 0; yi < 16; yi++) begin
        repeat ($urandom_range(0, 1)) tick();
        bus.out_ready = 1'b0;
        do_accept(8'(xi), 4'(yi));
        wait_out(cyc);
        if (yi == 0) begin
          eq = 8'hFF; er = 4'(xi); edz = 1'b1;
        end else begin
          eq = 8'(xi / yi); er = 4'(xi % yi); edz = 1'b0;
        end
        ok = bus.out_valid && ({bus.q, bus.r, bus.dz} === {eq, er, edz});
        repeat ($urandom_range(0, 2)) begin
          tick();
          if (!bus.out_valid || {bus.q, bus.r, bus.dz} !== {eq, er, edz}) ok = 1'b0;
        end
        bus.out_ready = 1'b1;
        tick();
        if (bus.out_valid) ok = 1'b0;
        n_vec++;
        if (!ok) begin
          n_err++;
          $display("FAIL sweep x=%0d y=%0d: valid=%0b q=%0d r=%0d dz=%0b, required q=%0d r=%0d dz=%0b once",
                   xi, yi, bus.out_valid, bus.q, bus.r, bus.dz, eq, er, edz);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_backpressure();
    test_reset_midrun();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end
endmodule
